// File: rtl/sw_pe_affine.sv
// Smith-Waterman / Needleman-Wunsch systolic processing element with affine gaps.
// Scores are biased by ZERO; every addition saturates to the unsigned score range.
module sw_pe_affine #(
    parameter int unsigned              SCORE_WIDTH = 12,
    parameter int unsigned              COL_WIDTH   = 10,
    parameter logic [COL_WIDTH-1:0]     ROW_ID      = '0,
    parameter logic [SCORE_WIDTH-1:0]   ZERO        = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    q_ld,
    input  logic [1:0]              query,
    input  logic                    mode_local,
    input  logic                    en_in,
    input  logic                    last_in,
    input  logic [1:0]              data_in,
    input  logic [SCORE_WIDTH-1:0]  h_in,
    input  logic [SCORE_WIDTH-1:0]  f_in,
    input  logic [SCORE_WIDTH-1:0]  bnd_diag,
    input  logic [SCORE_WIDTH-1:0]  bnd_left,
    input  logic [SCORE_WIDTH-1:0]  high_in,
    input  logic [COL_WIDTH-1:0]    hrow_in,
    input  logic [COL_WIDTH-1:0]    hcol_in,
    input  logic [SCORE_WIDTH-1:0]  match,
    input  logic [SCORE_WIDTH-1:0]  mismatch,
    input  logic [SCORE_WIDTH-1:0]  gap_open,
    input  logic [SCORE_WIDTH-1:0]  gap_extend,
    output logic [1:0]              data_out,
    output logic                    en_out,
    output logic                    last_out,
    output logic [SCORE_WIDTH-1:0]  h_out,
    output logic [SCORE_WIDTH-1:0]  f_out,
    output logic [SCORE_WIDTH-1:0]  high_out,
    output logic [COL_WIDTH-1:0]    hrow_out,
    output logic [COL_WIDTH-1:0]    hcol_out,
    output logic                    vld
);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_CALC = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    localparam int unsigned XW = SCORE_WIDTH + 2;

    function automatic logic signed [XW-1:0] sext(input logic [SCORE_WIDTH-1:0] v);
        return {{2{v[SCORE_WIDTH-1]}}, v};
    endfunction

    // Two guard bits: bit XW-1 flags underflow, bit SCORE_WIDTH flags overflow.
    function automatic logic [SCORE_WIDTH-1:0] sat_add(input logic [SCORE_WIDTH-1:0] a,
                                                       input logic signed [XW-1:0] p);
        logic signed [XW-1:0] s;
        s = $signed({2'b00, a}) + p;
        if (s[XW-1])
            return '0;
        else if (s[SCORE_WIDTH])
            return '1;
        else
            return s[SCORE_WIDTH-1:0];
    endfunction

    function automatic logic [SCORE_WIDTH-1:0] max2(input logic [SCORE_WIDTH-1:0] a,
                                                    input logic [SCORE_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [2:0]             r_state;
    logic [1:0]             r_query;
    logic                   r_local;
    logic [SCORE_WIDTH-1:0] r_diag;
    logic [SCORE_WIDTH-1:0] r_hleft;
    logic [SCORE_WIDTH-1:0] r_eleft;
    logic [COL_WIDTH-1:0]   r_col;
    logic [SCORE_WIDTH-1:0] r_best;
    logic [COL_WIDTH-1:0]   r_best_col;
    logic [1:0]             r_data;
    logic                   r_en;
    logic                   r_last;
    logic [SCORE_WIDTH-1:0] r_h;
    logic [SCORE_WIDTH-1:0] r_f;
    logic [SCORE_WIDTH-1:0] r_high;
    logic [COL_WIDTH-1:0]   r_hrow;
    logic [COL_WIDTH-1:0]   r_hcol;
    logic                   r_vld;

    logic                   w_idle;
    logic                   w_beat;
    logic                   w_local;
    logic [SCORE_WIDTH-1:0] w_diag;
    logic [SCORE_WIDTH-1:0] w_hleft;
    logic [SCORE_WIDTH-1:0] w_eleft;
    logic [COL_WIDTH-1:0]   w_col;
    logic [SCORE_WIDTH-1:0] w_s;
    logic signed [XW-1:0]   w_open;
    logic [SCORE_WIDTH-1:0] w_e;
    logic [SCORE_WIDTH-1:0] w_f;
    logic [SCORE_WIDTH-1:0] w_hraw;
    logic [SCORE_WIDTH-1:0] w_h;
    logic [SCORE_WIDTH-1:0] w_own;
    logic [COL_WIDTH-1:0]   w_own_col;
    logic                   w_own_wins;

    // The first beat of a row takes its left/diagonal context from the boundary inputs.
    always_comb begin
        w_idle    = (r_state == S_IDLE);
        w_beat    = en_in && (w_idle || (r_state == S_CALC));
        w_local   = w_idle ? mode_local : r_local;
        w_diag    = w_idle ? bnd_diag : r_diag;
        w_hleft   = w_idle ? bnd_left : r_hleft;
        w_eleft   = w_idle ? '0 : r_eleft;
        w_col     = w_idle ? {{(COL_WIDTH-1){1'b0}}, 1'b1} : r_col;
        w_s       = (data_in == r_query) ? match : mismatch;
        w_open    = sext(gap_open) + sext(gap_extend);
        w_e       = max2(sat_add(w_hleft, w_open), sat_add(w_eleft, sext(gap_extend)));
        w_f       = max2(sat_add(h_in, w_open), sat_add(f_in, sext(gap_extend)));
        w_hraw    = max2(sat_add(w_diag, sext(w_s)), max2(w_e, w_f));
        w_h       = (w_local && (w_hraw < ZERO)) ? ZERO : w_hraw;
        // Local mode keeps the earliest maximum of the row; global only the current beat.
        if (w_local && !w_idle && (r_best >= w_h)) begin
            w_own     = r_best;
            w_own_col = r_best_col;
        end else begin
            w_own     = w_h;
            w_own_col = w_col;
        end
        w_own_wins = (w_own > high_in);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_query    <= 2'b00;
            r_local    <= 1'b0;
            r_diag     <= ZERO;
            r_hleft    <= ZERO;
            r_eleft    <= '0;
            r_col      <= '0;
            r_best     <= ZERO;
            r_best_col <= '0;
            r_data     <= 2'b00;
            r_en       <= 1'b0;
            r_last     <= 1'b0;
            r_h        <= ZERO;
            r_f        <= '0;
            r_high     <= ZERO;
            r_hrow     <= '0;
            r_hcol     <= '0;
            r_vld      <= 1'b0;
        end else begin
            r_en  <= w_beat;
            r_vld <= (r_state == S_DONE);
            if (w_beat) begin
                r_data     <= data_in;
                r_last     <= last_in;
                r_h        <= w_h;
                r_f        <= w_f;
                r_eleft    <= w_e;
                r_hleft    <= w_h;
                r_diag     <= h_in;
                r_col      <= (&w_col) ? w_col : w_col + 1'b1;
                r_best     <= w_own;
                r_best_col <= w_own_col;
                if (w_own_wins) begin
                    r_high <= w_own;
                    r_hrow <= ROW_ID;
                    r_hcol <= w_own_col;
                end else begin
                    r_high <= high_in;
                    r_hrow <= hrow_in;
                    r_hcol <= hcol_in;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (q_ld)
                        r_query <= query;
                    if (en_in) begin
                        r_local <= mode_local;
                        r_state <= last_in ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (en_in && last_in)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out = r_data;
    assign en_out   = r_en;
    assign last_out = r_last;
    assign h_out    = r_h;
    assign f_out    = r_f;
    assign high_out = r_high;
    assign hrow_out = r_hrow;
    assign hcol_out = r_hcol;
    assign vld      = r_vld;

endmodule

// File: tb/tb_sw_pe_affine.sv
// Directed bench for sw_pe_affine: W=12, ZERO=2048, match=+2, mismatch=-1, open=-3, extend=-1.
module tb_sw_pe_affine;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_ld;
    logic [1:0]  query;
    logic        mode_local;
    logic        en_in;
    logic        last_in;
    logic [1:0]  data_in;
    logic [11:0] h_in, f_in, bnd_diag, bnd_left, high_in;
    logic [9:0]  hrow_in, hcol_in;
    logic [11:0] match, mismatch, gap_open, gap_extend;
    logic [1:0]  data_out;
    logic        en_out, last_out, vld;
    logic [11:0] h_out, f_out, high_out;
    logic [9:0]  hrow_out, hcol_out;

    int total = 0;
    int bad   = 0;

    sw_pe_affine #(
        .SCORE_WIDTH (12),
        .COL_WIDTH   (10),
        .ROW_ID      (10'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_ld       (q_ld),
        .query      (query),
        .mode_local (mode_local),
        .en_in      (en_in),
        .last_in    (last_in),
        .data_in    (data_in),
        .h_in       (h_in),
        .f_in       (f_in),
        .bnd_diag   (bnd_diag),
        .bnd_left   (bnd_left),
        .high_in    (high_in),
        .hrow_in    (hrow_in),
        .hcol_in    (hcol_in),
        .match      (match),
        .mismatch   (mismatch),
        .gap_open   (gap_open),
        .gap_extend (gap_extend),
        .data_out   (data_out),
        .en_out     (en_out),
        .last_out   (last_out),
        .h_out      (h_out),
        .f_out      (f_out),
        .high_out   (high_out),
        .hrow_out   (hrow_out),
        .hcol_out   (hcol_out),
        .vld        (vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_h"},    32'(h_out),    2048);
        chk({pfx, "_f"},    32'(f_out),    0);
        chk({pfx, "_high"}, 32'(high_out), 2048);
        chk({pfx, "_hrow"}, 32'(hrow_out), 0);
        chk({pfx, "_hcol"}, 32'(hcol_out), 0);
        chk({pfx, "_data"}, 32'(data_out), 0);
        chk({pfx, "_en"},   32'(en_out),   0);
        chk({pfx, "_last"}, 32'(last_out), 0);
        chk({pfx, "_vld"},  32'(vld),      0);
    endtask

    initial begin
        rst = 1'b0; q_ld = 1'b0; query = 2'b00; mode_local = 1'b1;
        en_in = 1'b0; last_in = 1'b0; data_in = 2'b00;
        h_in = 12'd2048; f_in = 12'd0; bnd_diag = 12'd2048; bnd_left = 12'd2048;
        high_in = 12'd0; hrow_in = 10'd0; hcol_in = 10'd0;
        match = 12'd2; mismatch = 12'hFFF; gap_open = 12'hFFD; gap_extend = 12'hFFF;

        // Reset state
        tick(); tick();
        chk_reset("rst");
        rst = 1'b1;

        // Load query A, local single matching beat
        q_ld = 1'b1; query = 2'b00;
        tick();
        q_ld = 1'b0;
        en_in = 1'b1; last_in = 1'b1; data_in = 2'b00; mode_local = 1'b1;
        tick();
        en_in = 1'b0; last_in = 1'b0;
        chk("match_h",     32'(h_out),    2050);
        chk("match_f",     32'(f_out),    2044);
        chk("match_high",  32'(high_out), 2050);
        chk("match_hrow",  32'(hrow_out), 3);
        chk("match_hcol",  32'(hcol_out), 1);
        chk("match_en",    32'(en_out),   1);
        chk("match_last",  32'(last_out), 1);
        chk("match_vld0",  32'(vld),      0);
        tick();
        chk("match_vld1",  32'(vld),      1);
        tick();
        chk("match_vld2",  32'(vld),      0);
        chk("match_en2",   32'(en_out),   0);

        // Mismatch, local: floored at ZERO
        en_in = 1'b1; last_in = 1'b1; data_in = 2'b10; mode_local = 1'b1;
        tick();
        en_in = 1'b0; last_in = 1'b0;
        chk("mis_loc_h",    32'(h_out),    2048);
        chk("mis_loc_data", 32'(data_out), 2);
        tick(); tick();

        // Mismatch, global: no floor
        en_in = 1'b1; last_in = 1'b1; data_in = 2'b10; mode_local = 1'b0;
        tick();
        en_in = 1'b0; last_in = 1'b0;
        chk("mis_glb_h", 32'(h_out), 2047);
        chk("mis_glb_f", 32'(f_out), 2044);
        tick(); tick();

        // Saturation high
        en_in = 1'b1; last_in = 1'b1; data_in = 2'b00; mode_local = 1'b1; bnd_diag = 12'd4095;
        tick();
        en_in = 1'b0; last_in = 1'b0; bnd_diag = 12'd2048;
        chk("sat_hi_h", 32'(h_out), 4095);
        tick(); tick();

        // Saturation low on F, global
        en_in = 1'b1; last_in = 1'b1; data_in = 2'b00; mode_local = 1'b0; h_in = 12'd1; f_in = 12'd0;
        tick();
        en_in = 1'b0; last_in = 1'b0; h_in = 12'd2048;
        chk("sat_lo_f", 32'(f_out), 0);
        chk("sat_lo_h", 32'(h_out), 2050);
        tick(); tick();

        // Stall between two beats; q_ld during the row must be ignored
        en_in = 1'b1; last_in = 1'b0; data_in = 2'b00; mode_local = 1'b1; h_in = 12'd2050;
        tick();
        chk("stall_b1_h",  32'(h_out),  2050);
        chk("stall_b1_f",  32'(f_out),  2046);
        chk("stall_b1_en", 32'(en_out), 1);
        en_in = 1'b0; q_ld = 1'b1; query = 2'b10; h_in = 12'd2048; mode_local = 1'b0;
        tick();
        chk("stall_c2_en", 32'(en_out), 0);
        chk("stall_c2_h",  32'(h_out),  2050);
        tick();
        chk("stall_c3_en", 32'(en_out), 0);
        chk("stall_c3_f",  32'(f_out),  2046);
        q_ld = 1'b0; en_in = 1'b1; last_in = 1'b1; data_in = 2'b00;
        tick();
        en_in = 1'b0; last_in = 1'b0;
        chk("stall_b2_h",    32'(h_out),    2052);
        chk("stall_b2_f",    32'(f_out),    2044);
        chk("stall_b2_high", 32'(high_out), 2052);
        chk("stall_b2_hcol", 32'(hcol_out), 2);
        chk("stall_b2_en",   32'(en_out),   1);
        tick(); tick();

        // Tie with left neighbour: neighbour's position kept
        en_in = 1'b1; last_in = 1'b1; data_in = 2'b00; mode_local = 1'b1;
        high_in = 12'd2050; hrow_in = 10'd5; hcol_in = 10'd1;
        tick();
        en_in = 1'b0; last_in = 1'b0;
        chk("tie_high", 32'(high_out), 2050);
        chk("tie_hrow", 32'(hrow_out), 5);
        chk("tie_hcol", 32'(hcol_out), 1);
        high_in = 12'd0; hrow_in = 10'd0; hcol_in = 10'd0;
        tick(); tick();

        // Global mode: high reflects only the last beat's H
        en_in = 1'b1; last_in = 1'b0; data_in = 2'b00; mode_local = 1'b0; bnd_diag = 12'd2100;
        tick();
        chk("glb_b1_h",    32'(h_out),    2102);
        chk("glb_b1_high", 32'(high_out), 2102);
        bnd_diag = 12'd2048; last_in = 1'b1; data_in = 2'b10;
        tick();
        en_in = 1'b0; last_in = 1'b0;
        chk("glb_b2_h",    32'(h_out),    2098);
        chk("glb_b2_high", 32'(high_out), 2098);
        chk("glb_b2_hcol", 32'(hcol_out), 2);
        tick(); tick();

        // Reset in the middle of a row
        en_in = 1'b1; last_in = 1'b0; data_in = 2'b00; mode_local = 1'b1;
        tick();
        chk("mid_pre_h", 32'(h_out), 2050);
        en_in = 1'b0; rst = 1'b0;
        tick();
        chk_reset("mid_rst");
        rst = 1'b1;
        // An IDLE first beat takes bnd_diag; a stuck CALC state would use the stored diagonal
        en_in = 1'b1; last_in = 1'b1; data_in = 2'b00; bnd_diag = 12'd2100;
        tick();
        en_in = 1'b0; last_in = 1'b0;
        chk("mid_post_h",    32'(h_out),    2102);
        chk("mid_post_hcol", 32'(hcol_out), 1);
        tick();
        chk("mid_post_vld",  32'(vld),      1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_pe_affine.md
SW_PE_AFFINE -- requirements
Module: sw_pe_affine

Interface
REQ-001 Parameter SCORE_WIDTH, default 12, width of the biased score and penalty buses.
REQ-002 Parameter COL_WIDTH, default 10, width of the target column counter.
REQ-003 Parameter ROW_ID, default 0, row index of this PE in the systolic array, COL_WIDTH bits.
REQ-004 Parameter ZERO, default 2**(SCORE_WIDTH-1), biased zero.
REQ-005 Ports (name, direction, width, meaning), one per line:
 clk  in  1  clock
 rst  in  1  reset, synchronous, active-low
 q_ld  in  1  load query base (honoured in IDLE only)
 query  in  2  query base (A=00, G=01, T=10, C=11)
 mode_local  in  1  1=local (floor at ZERO), 0=global; sampled at first beat
 en_in  in  1  beat valid from left neighbour
 last_in  in  1  marks final target base of the row
 data_in  in  2  target base
 h_in, f_in  in  SCORE_WIDTH  H and F of the upper row, same column
 bnd_diag, bnd_left  in  SCORE_WIDTH  H[i-1][0] and H[i][0], sampled at first beat
 high_in  in  SCORE_WIDTH  best score from left neighbour
 hrow_in, hcol_in  in  COL_WIDTH  position of high_in
 match, mismatch, gap_open, gap_extend  in  SCORE_WIDTH  two's-complement penalties
 data_out, en_out, last_out  out  2/1/1  registered pass-through
 h_out, f_out, high_out  out  SCORE_WIDTH  registered scores
 hrow_out, hcol_out  out  COL_WIDTH  position of high_out
 vld  out  1  one-cycle result pulse

Function
REQ-006 States IDLE, CALC, DONE; one-hot encoded; illegal encoding -> IDLE next cycle.
REQ-007 IDLE: q_ld=1 loads query register; en_in=1 performs first beat (col=1, diag=bnd_diag, left H=bnd_left, left E=0) and moves to CALC.
REQ-008 CALC: en_in=1 performs a beat; en_in=0 stalls, with all registers held and en_out=0.
REQ-009 A beat with last_in=1 -> DONE; DONE asserts vld for exactly one cycle, then returns to IDLE.
REQ-010 Per beat: s=(data_in==query)?match:mismatch; E=max(Hleft+gap_open+gap_extend, Eleft+gap_extend); F=max(h_in+gap_open+gap_extend, f_in+gap_extend); H=max(diag+s, E, F).
REQ-011 Local mode: H floored at ZERO; global mode: no floor.
REQ-012 All additions saturate to [0, 2**SCORE_WIDTH-1]; no wrap-around.
REQ-013 After a beat: h_out=H, f_out=F, internal E and Hleft updated, diag<=h_in, col<=col+1; col saturates at all-ones.
REQ-014 Latency: one cycle; data_out, en_out, last_out equal the previous cycle's data_in, en_in&beat, last_in.
REQ-015 High: candidate=max(high_in, own best H); own H wins only when strictly greater; position = (ROW_ID, col) for own, (hrow_in, hcol_in) otherwise.
REQ-016 Global mode: own best is the H of the last beat only.
REQ-017 Any q_ld in CALC/DONE is ignored.

Reset
REQ-018 rst=0 at a clock edge forces IDLE: h_out=ZERO, f_out=0, high_out=ZERO, hrow/hcol_out=0, data_out=0, en_out=0, last_out=0, vld=0, col=0, query=00; this applies mid-row as well.

Verification (W=12, ZERO=2048, match=+2, mismatch=-1, gap_open=-3, gap_extend=-1)
REQ-019 Reset mid-CALC -> next cycle all outputs equal REQ-018 values, state IDLE.
REQ-020 Local, query A, single beat data A, last=1, h_in=2048, f_in=0, bnd=2048 -> h_out=2050, high_out=2050, hcol_out=1, vld pulse 2 cycles after the beat.
REQ-021 Local, data T vs query A, same inputs -> h_out=2048 (floored); global -> h_out=2047, f_out=2044.
REQ-022 Saturation: bnd_diag=4095, match beat -> h_out=4095; h_in=1, f_in=0, global -> f_out=0.
REQ-023 Stall: beats at cycles 0, 3, with en_in=0 at cycles 1-2 -> outputs held, en_out=0 at cycles 2-3, second beat hcol=2.
REQ-024 Tie: high_in=2050 from ROW 5 col 1, own H=2050 -> high_out=2050, hrow_out=5.
